register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised general-purpose register file with a per-register busy scoreboard. It is the next generation of the CPU's 32x32 register file.
- Two combinational read ports with write-through bypass. One write port with byte enables. Register 0 can be hardwired to zero.
- Tracks registers awaiting a result from multi-cycle units (load, mult/div) so that decode can stall on RAW and WAW hazards.
- Sits between decode (issue, busy lookup) and writeback.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- ZERO_HARDWIRED, 1, if 1 then register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; low clears all state.
- read_register_1  input  ADDR_WIDTH  read port 1 index.
- read_register_2  input  ADDR_WIDTH  read port 2 index.
- read_data_1  output  DATA_WIDTH  port 1 data.
- read_data_2  output  DATA_WIDTH  port 2 data.
- busy_1  output  1  register at read_register_1 has a pending producer.
- busy_2  output  1  register at read_register_2 has a pending producer.
- write_register  input  ADDR_WIDTH  write index.
- write_data  input  DATA_WIDTH  write data.
- write_byte_enable  input  DATA_WIDTH/8  per-byte write enable; bit i covers bits 8i+7:8i.
- Regwrite  input  1  write strobe.
- issue_valid  input  1  decode requests to mark issue_register busy.
- issue_register  input  ADDR_WIDTH  destination of a multi-cycle op.
- issue_ready  output  1  issue_register is not busy (or is register 0 when ZERO_HARDWIRED=1).
- outstanding_count  output  ADDR_WIDTH+1  number of busy registers.
- register_v0  output  DATA_WIDTH  stored value of register 2 (debug/testbench); no bypass.

Behaviour:
- Reset low (asynchronous): all registers = 0, all busy bits = 0, outstanding_count = 0.
- While reset is low: read_data_1/2 = 0, busy_1/2 = 0, issue_ready = 1, register_v0 = 0.
- Write: at the rising clk edge, if Regwrite=1, each byte of write_register with its write_byte_enable bit set takes the matching write_data byte. Other bytes hold.
- Writes to register 0 are dropped when ZERO_HARDWIRED=1.
- Read: combinational, zero latency. The output is the stored value, except when Regwrite=1 and write_register equals the read index (and the index is not hardwired 0). In that case the enabled bytes come from write_data (bypass) and the disabled bytes from storage.
- Reading register 0 with ZERO_HARDWIRED=1 always returns 0.
- Both read ports may address the same register; both return identical data.
- Issue accept = issue_valid & issue_ready. On accept, busy[issue_register] is set at the next edge.
- issue_valid with issue_ready=0 is ignored; decode must hold the request until issue_ready=1 (WAW stall).
- Busy clear: Regwrite=1 clears busy[write_register] at the edge, regardless of byte enables.
- A write to a non-busy register is a plain write; busy stays 0.
- Same edge, issue accept and Regwrite to the same register: not possible by construction, since the register must be non-busy to issue. If it does occur, the set wins and busy = 1.
- Same edge, issue to register A and write-clear of register B≠A: both take effect; outstanding_count is unchanged.
- busy_1/busy_2 reflect registered busy bits only; a same-cycle clearing write is not bypassed into busy.
- outstanding_count = +1 on accept only, −1 on clear only, unchanged on both or neither. It never wraps: its maximum is 2**ADDR_WIDTH, so its width is ADDR_WIDTH+1.
- Issue with issue_register=0 and ZERO_HARDWIRED=1: accepted (issue_ready=1), no busy bit set, count unchanged.

Test Plan:
- Reset low mid-run after writing 0xDEADBEEF to reg 5 → read_data_1 = 0 immediately (asynchronous); after release, reg 5 reads 0 and outstanding_count = 0.
- Write reg 2 = 0x12345678, byte enables 4'b1111; next cycle write 0xAABBCCDD with 4'b0101 → register_v0 = 0x12BB56DD.
- Regwrite reg 7 = 0xCAFEF00D while read_register_1 = 7 (stored 0) → read_data_1 = 0xCAFEF00D in the same cycle.
- Write reg 0 = 0xFFFFFFFF → read of reg 0 returns 0.
- Issue reg 9 → busy_1 = 1 (read_register_1 = 9), issue_ready = 0 for issue_register = 9, count = 1. Regwrite reg 9 → next cycle busy_1 = 0, count = 0.
- Same edge: issue reg 3 and write-clear busy reg 4 → count unchanged, busy[3] = 1, busy[4] = 0. Issue 32 distinct registers with ZERO_HARDWIRED=0 → count = 32 with no wrap.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb
//   General-purpose register file with a per-register busy scoreboard.
//   Two combinational read ports with write-through bypass on enabled bytes,
//   one byte-enabled write port, optional hardwired-zero register 0, and
//   busy tracking for registers awaiting multi-cycle results.
// Ports:
//   clk, reset (async, active-low)
//   read_register_1/2 -> read_data_1/2, busy_1/2       decode read/lookup
//   write_register, write_data, write_byte_enable, Regwrite   writeback
//   issue_valid, issue_register -> issue_ready          issue handshake
//   outstanding_count                                   number of busy regs
//   register_v0                                         stored reg 2, no bypass
module register_file_sb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     read_register_1,
    input  logic [ADDR_WIDTH-1:0]     read_register_2,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    output logic                      busy_1,
    output logic                      busy_2,
    input  logic [ADDR_WIDTH-1:0]     write_register,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_byte_enable,
    input  logic                      Regwrite,
    input  logic                      issue_valid,
    input  logic [ADDR_WIDTH-1:0]     issue_register,
    output logic                      issue_ready,
    output logic [ADDR_WIDTH:0]       outstanding_count,
    output logic [DATA_WIDTH-1:0]     register_v0
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]      busy_r;
    logic [ADDR_WIDTH:0]   count_r;

    logic [DATA_WIDTH-1:0] wr_mask_s;
    logic                  accept_s;
    logic                  set_s;
    logic                  clr_s;
    logic                  issue_ready_s;

    // True when addr names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_HARDWIRED != 0) && (addr == {ADDR_WIDTH{1'b0}});
    endfunction

    // Expand per-byte enables into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] expand_be(input logic [NBYTES-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NBYTES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Read value for one port: hardwired zero, else storage with bypass of enabled bytes.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [DATA_WIDTH-1:0] stored);
        logic [DATA_WIDTH-1:0] v;
        if (is_zero_reg(addr)) begin
            v = {DATA_WIDTH{1'b0}};
        end else if (Regwrite && (write_register == addr)) begin
            v = (stored & ~wr_mask_s) | (write_data & wr_mask_s);
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Issue handshake and scoreboard update terms.
    always_comb begin
        wr_mask_s     = expand_be(write_byte_enable);
        issue_ready_s = is_zero_reg(issue_register) || !busy_r[issue_register];
        accept_s      = issue_valid && issue_ready_s;
        // Register 0 (when hardwired) is accepted but never marked busy.
        set_s         = accept_s && !is_zero_reg(issue_register);
        // Only a write that actually retires a busy bit lowers the count.
        clr_s         = Regwrite && busy_r[write_register];
    end

    // Read ports; forced to zero while reset is held so bypass cannot leak through.
    always_comb begin
        if (!reset) begin
            read_data_1 = {DATA_WIDTH{1'b0}};
            read_data_2 = {DATA_WIDTH{1'b0}};
        end else begin
            read_data_1 = read_port(read_register_1, regs_r[read_register_1]);
            read_data_2 = read_port(read_register_2, regs_r[read_register_2]);
        end
    end

    // Register storage with byte-enabled writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (Regwrite && !is_zero_reg(write_register)) begin
            regs_r[write_register] <= (regs_r[write_register] & ~wr_mask_s)
                                    | (write_data & wr_mask_s);
        end
    end

    // Busy bits: clear on writeback, then set on issue so a same-register collision stays busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (Regwrite) begin
                busy_r[write_register] <= 1'b0;
            end
            if (set_s) begin
                busy_r[issue_register] <= 1'b1;
            end
        end
    end

    // Outstanding counter; set and clear in the same edge cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case ({set_s, clr_s})
                2'b10:   count_r <= count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign busy_1            = busy_r[read_register_1];
    assign busy_2            = busy_r[read_register_2];
    assign issue_ready       = issue_ready_s;
    assign outstanding_count = count_r;
    assign register_v0       = regs_r[2];

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  read_register_1, read_register_2, write_register, issue_register;
    logic [31:0] write_data;
    logic [3:0]  write_byte_enable;
    logic        Regwrite, issue_valid;

    // Index 0: ZERO_HARDWIRED=1, index 1: ZERO_HARDWIRED=0.
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic [31:0] v0  [2];
    logic        b1  [2];
    logic        b2  [2];
    logic        rdy [2];
    logic [5:0]  cnt [2];

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_HARDWIRED(1)) dut_zh (
        .clk(clk), .reset(reset),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(rd1[0]), .read_data_2(rd2[0]), .busy_1(b1[0]), .busy_2(b2[0]),
        .write_register(write_register), .write_data(write_data),
        .write_byte_enable(write_byte_enable), .Regwrite(Regwrite),
        .issue_valid(issue_valid), .issue_register(issue_register),
        .issue_ready(rdy[0]), .outstanding_count(cnt[0]), .register_v0(v0[0]));

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_HARDWIRED(0)) dut_nz (
        .clk(clk), .reset(reset),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(rd1[1]), .read_data_2(rd2[1]), .busy_1(b1[1]), .busy_2(b2[1]),
        .write_register(write_register), .write_data(write_data),
        .write_byte_enable(write_byte_enable), .Regwrite(Regwrite),
        .issue_valid(issue_valid), .issue_register(issue_register),
        .issue_ready(rdy[1]), .outstanding_count(cnt[1]), .register_v0(v0[1]));

    typedef struct packed {
        logic [1:0][31:0] rd1;
        logic [1:0][31:0] rd2;
        logic [1:0][31:0] v0;
        logic [1:0]       b1;
        logic [1:0]       b2;
        logic [1:0]       rdy;
        logic [1:0][5:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: architectural contents and pending-producer flags.
    logic [31:0] mem [2][32];
    bit          bsy [2][32];

    function automatic bit zh(input int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
        if (!reset) return 32'h0;
        if (zh(k) && a == 5'd0) return 32'h0;
        if (Regwrite && write_register == a) return merge(mem[k][a], write_data, write_byte_enable);
        return mem[k][a];
    endfunction

    function automatic logic [5:0] m_count(input int k);
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(bsy[k][r]);
        return 6'(n);
    endfunction

    function automatic logic m_ready(input int k);
        return (zh(k) && issue_register == 5'd0) || !bsy[k][issue_register];
    endfunction

    // Drive one cycle of stimulus, push the expected outputs, advance the model past the edge.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic iv,
                        input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        reset = rst; Regwrite = we; write_register = wa; write_data = wd;
        write_byte_enable = be; issue_valid = iv; issue_register = ir;
        read_register_1 = r1; read_register_2 = r2;
        if (!rst) begin
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 32; r++) begin mem[k][r] = 32'h0; bsy[k][r] = 1'b0; end
        end
        for (int k = 0; k < 2; k++) begin
            e.rd1[k] = m_read(k, r1);
            e.rd2[k] = m_read(k, r2);
            e.v0[k]  = mem[k][2];
            e.b1[k]  = bsy[k][r1];
            e.b2[k]  = bsy[k][r2];
            e.rdy[k] = m_ready(k);
            e.cnt[k] = m_count(k);
        end
        sb_q.push_back(e);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                acc = iv && m_ready(k);
                if (we) begin
                    bsy[k][wa] = 1'b0;
                    if (!(zh(k) && wa == 5'd0)) mem[k][wa] = merge(mem[k][wa], wd, be);
                end
                if (acc && !(zh(k) && ir == 5'd0)) bsy[k][ir] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk("read_data_1", k, rd1[k], e.rd1[k]);
                    chk("read_data_2", k, rd2[k], e.rd2[k]);
                    chk("register_v0", k, v0[k], e.v0[k]);
                    chk("busy_1", k, {31'h0, b1[k]}, {31'h0, e.b1[k]});
                    chk("busy_2", k, {31'h0, b2[k]}, {31'h0, e.b2[k]});
                    chk("issue_ready", k, {31'h0, rdy[k]}, {31'h0, e.rdy[k]});
                    chk("outstanding_count", k, {26'h0, cnt[k]}, {26'h0, e.cnt[k]});
                end
            end
        end
    end

    initial begin
        reset = 1'b0; Regwrite = 1'b0; write_register = 5'd0; write_data = 32'h0;
        write_byte_enable = 4'h0; issue_valid = 1'b0; issue_register = 5'd0;
        read_register_1 = 5'd0; read_register_2 = 5'd0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin mem[k][r] = 32'h0; bsy[k][r] = 1'b0; end

        // Reset state, including an attempted write and issue while held.
        step(1'b0, 1'b1, 5'd5, 32'h11111111, 4'hF, 1'b1, 5'd6, 5'd5, 5'd6);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd2);
        // Write 0xDEADBEEF to reg 5 (bypassed), read it back, then async reset mid-run.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd5);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd8, 5'd5, 5'd8);
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd8, 5'd5, 5'd8);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd8, 5'd5, 5'd8);
        // Byte-enabled merge into reg 2.
        step(1'b1, 1'b1, 5'd2, 32'h12345678, 4'b1111, 1'b0, 5'd0, 5'd2, 5'd1);
        step(1'b1, 1'b1, 5'd2, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd2, 5'd2);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd2, 5'd2);
        // Same-cycle bypass of reg 7 and partial bypass.
        step(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b1, 1'b1, 5'd7, 32'h01020304, 4'b1010, 1'b0, 5'd0, 5'd7, 5'd2);
        // Write reg 0: dropped only when hardwired.
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd1);
        // Issue reg 9, observe busy/ready/count, then retire it.
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd1);
        step(1'b1, 1'b1, 5'd9, 32'h99999999, 4'b0001, 1'b0, 5'd9, 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd9, 5'd9, 5'd9);
        // Issue reg 4, then same edge: issue reg 3 and retire reg 4.
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4, 5'd3, 5'd4);
        step(1'b1, 1'b1, 5'd4, 32'h44444444, 4'hF, 1'b1, 5'd3, 5'd3, 5'd4);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd3, 5'd3, 5'd4);
        // Issue reg 0 plus every other register; no wrap at 32.
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(r), 5'(r), 5'((r + 31) % 32));
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 5'd0, 5'd31);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd31);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'($urandom_range(0, 9) < 4), 5'($urandom), $urandom, 4'($urandom),
                 1'($urandom_range(0, 9) < 4), 5'($urandom), 5'($urandom), 5'($urandom));
        end
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
